// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state encoding and default sizing shared by the
// UART transmit arbiter and its round-robin selector.
package uart_arb_pkg;

    localparam int DEF_NUM_SRC     = 4;
    localparam int DEF_TIMEOUT_CYC = 255;

    // One transmitter shared by several message sources.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no owner, waiting for a request
        ST_SEND  = 2'd1,   // owner granted, waiting for a byte and a free transmitter
        ST_HOLD  = 2'd2,   // one cycle after the strobe, before tx_busy is trusted
        ST_DRAIN = 2'd3    // waiting for the transmitter to finish the frame
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector. Returns a one-hot vector
// marking the first requester strictly after ptr in circular order, or
// all zeros when nothing requests.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N     = DEF_NUM_SRC,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [PTR_W-1:0] idx;

    // Scan candidates from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_SRC message
// sources. A source is granted round-robin, keeps the grant for a whole
// message, and each byte is handed to the transmitter as a one-cycle
// tx_start strobe. All outputs are registered.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a message whose
// owner stalls (src_valid low in SEND) for TIMEOUT_CYC consecutive
// cycles. Without it SEND waits indefinitely and arb_timeout is 0.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   uart_clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_last,
    output logic [NUM_SRC-1:0]     src_ack,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   arb_timeout
);

    localparam int PTR_W = $clog2(NUM_SRC);

    // Reject out-of-range configurations at elaboration time.
    if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("uart_tx_arbiter: NUM_SRC must be 2..8 and TIMEOUT_CYC at least 1");
    end

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;     // last source served; search starts after it
    logic [PTR_W-1:0]   g_idx;      // index of the current owner
    logic               last_q;     // last flag of the byte most recently sent
    logic [NUM_SRC-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic [7:0]         src_byte [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_byte[i] = src_data[8*i +: 8];
    end

    rr_pick #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (src_req),
        .ptr (rr_ptr),
        .gnt (pick_oh)
    );

    // Convert the one-hot pick into an index for the data/valid muxes.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_oh[PTR_W'(i)]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] stall_cnt;    // consecutive SEND cycles without a byte
    logic             timeout_q;

    assign arb_timeout = timeout_q;
`else
    assign arb_timeout = 1'b0;
`endif

    // Arbitration FSM: grant, byte hand-off, frame drain and round-robin update.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            src_ack  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            rr_ptr   <= PTR_W'(NUM_SRC - 1);
            g_idx    <= '0;
            last_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
            src_ack  <= '0;
            tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (|src_req) begin
                        grant <= pick_oh;
                        g_idx <= pick_idx;
                        state <= ST_SEND;
`ifdef UART_ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                    end
                end

                ST_SEND: begin
                    if (src_valid[g_idx] && !tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= src_byte[g_idx];
                        src_ack  <= grant;
                        last_q   <= src_last[g_idx];
                        state    <= ST_HOLD;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    if (src_valid[g_idx]) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        rr_ptr    <= g_idx;
                        grant     <= '0;
                        stall_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
`endif
                end

                // The transmitter may not have raised tx_busy yet, so skip one cycle.
                ST_HOLD: begin
                    state <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            rr_ptr <= g_idx;
                            grant  <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench. Stimulus loads source
// message queues and pushes hand-computed expected bytes and grant order;
// a negedge monitor compares every tx_start strobe and every new grant.
// Define UART_ARB_TIMEOUT_EN for both bench and RTL to test the timeout.
module tb_uart_tx_arbiter;

    localparam int NSRC     = 4;
    localparam int TO_CYC   = 16;
    localparam int BUSY_LEN = 10;
    localparam int BUDGET   = 400;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    logic              uart_clk;
    logic              rst_n;
    logic [NSRC-1:0]   src_req;
    logic [NSRC-1:0]   src_valid;
    logic [8*NSRC-1:0] src_data;
    logic [NSRC-1:0]   src_last;
    logic [NSRC-1:0]   src_ack;
    logic [NSRC-1:0]   grant;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              arb_timeout;

    uart_tx_arbiter #(
        .NUM_SRC     (NSRC),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .uart_clk    (uart_clk),
        .rst_n       (rst_n),
        .src_req     (src_req),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_last    (src_last),
        .src_ack     (src_ack),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .arb_timeout (arb_timeout)
    );

    initial begin
        uart_clk = 1'b0;
        forever #5 uart_clk = ~uart_clk;
    end

    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    logic [8:0]      msg_q [NSRC][$];   // {last, data} per source
    exp_t            exp_q [$];
    int              exp_grant [$];
    logic [NSRC-1:0] stall = '0;
    logic            force_busy = 1'b0;
    int              busy_rem = 0;
    int              busy_fall_cyc = 0;
    logic [NSRC-1:0] owner_oh = '0;
    bit              mon_en = 1'b0;
    int              n_strobes = 0;
    int              last_strobe_cyc = -100;
    logic [NSRC-1:0] prev_grant = '0;
    logic [8:0]      head;
    logic            nb;
    exp_t            mon_e;
    int              exp_src;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NSRC-1:0] oh(input int s);
        logic [NSRC-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            if (msg_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic load(input int s, input logic [7:0] d, input logic last);
        msg_q[s].push_back({last, d});
    endtask

    task automatic push_exp(input int s, input logic [7:0] d);
        exp_t e;
        e.src  = s;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Source and transmitter models: react #1 after each rising edge.
    initial begin
        src_req   = '0;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        tx_busy   = 1'b0;
        forever begin
            @(posedge uart_clk);
            cyc++;
            #1;
            if (!rst_n) begin
                for (int i = 0; i < NSRC; i++) msg_q[i].delete();
                stall = '0;
            end else begin
                if (arb_timeout === 1'b1) begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (owner_oh[i]) begin
                            msg_q[i].delete();
                            stall[i] = 1'b0;
                        end
                    end
                end
                for (int i = 0; i < NSRC; i++) begin
                    if (src_ack[i] === 1'b1 && msg_q[i].size() > 0) void'(msg_q[i].pop_front());
                end
            end
            if (grant !== '0 && !$isunknown(grant)) owner_oh = grant;
            if (tx_start === 1'b1) busy_rem = BUSY_LEN;
            if (busy_rem > 0) begin
                nb = 1'b1;
                busy_rem--;
            end else begin
                nb = force_busy;
            end
            if (tx_busy && !nb) busy_fall_cyc = cyc;
            tx_busy = nb;
            for (int i = 0; i < NSRC; i++) begin
                head               = (msg_q[i].size() > 0) ? msg_q[i][0] : 9'h000;
                src_req[i]         = (msg_q[i].size() > 0);
                src_valid[i]       = (msg_q[i].size() > 0) && !stall[i];
                src_data[8*i +: 8] = head[7:0];
                src_last[i]        = head[8];
            end
        end
    end

    // Scoreboard monitor: compares strobes and new grants against the expected queues.
    always @(negedge uart_clk) begin
        if (mon_en) begin
            if (tx_start === 1'b1) begin
                n_strobes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(mon_e.data));
                    check("src_ack_at_strobe", 32'(src_ack), 32'(oh(mon_e.src)));
                    check("grant_at_strobe", 32'(grant), 32'(oh(mon_e.src)));
                end
                check("strobe_spacing_ge3", 32'((cyc - last_strobe_cyc) >= 3), 32'd1);
                last_strobe_cyc = cyc;
            end else if (src_ack !== '0) begin
                check("ack_without_strobe", 32'(src_ack), 32'd0);
            end
            if (grant !== '0 && grant !== prev_grant) begin
                if (exp_grant.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    exp_src = exp_grant.pop_front();
                    check("grant_order", 32'(grant), 32'(oh(exp_src)));
                end
            end
            prev_grant = grant;
        end
    end

    task automatic wait_quiet(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < BUDGET && !done; n++) begin
            @(negedge uart_clk);
            if (exp_q.size() == 0 && exp_grant.size() == 0 && grant == '0 && !tx_busy && all_empty())
                done = 1'b1;
        end
        if (!done) check({name, "_completion_budget"}, 32'd0, 32'd1);
    endtask

    task automatic wait_ack(input int s, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < BUDGET && !done; n++) begin
            @(negedge uart_clk);
            if (src_ack[s] === 1'b1) done = 1'b1;
        end
        if (!done) check({name, "_ack_budget"}, 32'd0, 32'd1);
    endtask

    task automatic wait_strobe(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < BUDGET && !done; n++) begin
            @(negedge uart_clk);
            if (tx_start === 1'b1) done = 1'b1;
        end
        if (!done) check({name, "_strobe_budget"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge uart_clk);
        rst_n = 1'b0;
        @(negedge uart_clk);
        rst_n = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_src_ack"}, 32'(src_ack), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_arb_timeout"}, 32'(arb_timeout), 32'd0);
    endtask

    initial begin
        int  k0;
        int  n0;
        int  seen;
        bit  done;

        rst_n = 1'b0;
        repeat (3) @(negedge uart_clk);
        check_outputs_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single source "Up": latency and two bytes with acks.
        k0 = cyc;
        load(0, 8'h55, 1'b0);
        load(0, 8'h70, 1'b1);
        push_exp(0, 8'h55);
        push_exp(0, 8'h70);
        exp_grant.push_back(0);
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge uart_clk);
            if (grant != '0) done = 1'b1;
        end
        check("latency_grant", 32'(cyc - k0), 32'd2);
        wait_strobe("single");
        check("latency_strobe", 32'(cyc - k0), 32'd3);
        wait_quiet("single");

        // Simultaneous requests 4'b1011 after reset: served 0, 1, 3 without interleave.
        pulse_reset();
        load(0, 8'h01, 1'b0); load(0, 8'h02, 1'b1);
        load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b0); load(1, 8'h13, 1'b1);
        load(3, 8'h31, 1'b1);
        push_exp(0, 8'h01); push_exp(0, 8'h02);
        push_exp(1, 8'h11); push_exp(1, 8'h12); push_exp(1, 8'h13);
        push_exp(3, 8'h31);
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(3);
        wait_quiet("simultaneous");

        // Fairness: src0 and src2 keep requesting, two messages each.
        load(0, 8'hA1, 1'b1); load(0, 8'hA2, 1'b1);
        load(2, 8'hC1, 1'b1); load(2, 8'hC2, 1'b1);
        push_exp(0, 8'hA1); push_exp(2, 8'hC1); push_exp(0, 8'hA2); push_exp(2, 8'hC2);
        exp_grant.push_back(0); exp_grant.push_back(2);
        exp_grant.push_back(0); exp_grant.push_back(2);
        wait_quiet("fairness");

        // Busy hold: transmitter busy on SEND entry for 20 cycles.
        force_busy = 1'b1;
        load(3, 8'h3C, 1'b1);
        push_exp(3, 8'h3C);
        exp_grant.push_back(3);
        n0 = n_strobes;
        repeat (20) @(negedge uart_clk);
        check("busy_no_strobe", 32'(n_strobes - n0), 32'd0);
        check("busy_grant_held", 32'(grant), 32'(oh(3)));
        force_busy = 1'b0;
        wait_strobe("busy");
        check("busy_strobe_after_fall", 32'(cyc - busy_fall_cyc), 32'd1);
        wait_quiet("busy");

        // Stall: src1 drops src_valid after its first byte, src2 waiting.
        load(1, 8'h41, 1'b0); load(1, 8'h42, 1'b0); load(1, 8'h43, 1'b1);
        load(2, 8'h51, 1'b1);
        push_exp(1, 8'h41);
`ifndef UART_ARB_TIMEOUT_EN
        push_exp(1, 8'h42);
        push_exp(1, 8'h43);
`endif
        push_exp(2, 8'h51);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        wait_ack(1, "stall");
        stall[1] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        done = 1'b0;
        for (int n = 0; n < BUDGET && !done; n++) begin
            @(negedge uart_clk);
            if (arb_timeout === 1'b1) done = 1'b1;
        end
        check("timeout_seen", 32'(done), 32'd1);
        check("timeout_delay", 32'(cyc - busy_fall_cyc), 32'(TO_CYC + 1));
        check("timeout_grant_cleared", 32'(grant), 32'd0);
        @(negedge uart_clk);
        check("timeout_one_cycle", 32'(arb_timeout), 32'd0);
`else
        seen = 0;
        repeat (100) begin
            @(negedge uart_clk);
            if (arb_timeout !== 1'b0) seen++;
        end
        check("no_timeout_pulse", 32'(seen), 32'd0);
        check("stall_grant_holds", 32'(grant), 32'(oh(1)));
        stall[1] = 1'b0;
`endif
        wait_quiet("stall");

        // Reset during DRAIN: message abandoned, next grant goes to src0.
        load(3, 8'h61, 1'b0);
        load(3, 8'h62, 1'b1);
        push_exp(3, 8'h61);
        exp_grant.push_back(3);
        wait_ack(3, "reset_drain");
        repeat (2) @(negedge uart_clk);
        rst_n = 1'b0;
        @(negedge uart_clk);
        check_outputs_zero("drain_reset");
        rst_n = 1'b1;
        load(2, 8'h71, 1'b1);
        load(0, 8'h0B, 1'b1);
        push_exp(0, 8'h0B);
        push_exp(2, 8'h71);
        exp_grant.push_back(0);
        exp_grant.push_back(2);
        wait_quiet("after_reset");

        repeat (5) @(negedge uart_clk);
        check("exp_bytes_left", 32'(exp_q.size()), 32'd0);
        check("exp_grants_left", 32'(exp_grant.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
